// File: rtl/stream_merge_2to1_if.sv
// Valid/ready beat channel shared by the merger's two inputs and its output.
// sel carries the source tag on the output side only.
interface stream_merge_2to1_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             last;
  logic             sel;
  logic             ready;

  modport master (output valid, output data, output last, output sel, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/stream_merge_2to1.sv
// Two-channel packet merger with packet-level round-robin and a registered output.
// dout.sel follows the downstream mux convention: 1 = channel 1, 0 = channel 2.
module stream_merge_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_merge_2to1_if.slave  din1,
  stream_merge_2to1_if.slave  din2,
  stream_merge_2to1_if.master dout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             lock_sel_r;
  logic             lock_sel_next_s;
  logic             prio_r;
  logic             prio_next_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_last_r;
  logic             out_sel_r;

  logic             load_s;
  logic             grant_any_s;
  logic             grant_sel_s;
  logic             ready1_s;
  logic             ready2_s;
  logic             acc1_s;
  logic             acc2_s;
  logic             accept_s;
  logic             beat_sel_s;
  logic [WIDTH-1:0] beat_data_s;
  logic             beat_last_s;

  assign load_s = !out_valid_r || dout.ready;

  // Grant selection: a locked packet owns the output until its last beat.
  always_comb begin
    grant_any_s = 1'b0;
    grant_sel_s = 1'b0;
    case (state_r)
      IDLE: begin
        case ({din1.valid, din2.valid})
          2'b10: begin
            grant_any_s = 1'b1;
            grant_sel_s = 1'b1;
          end
          2'b01: begin
            grant_any_s = 1'b1;
            grant_sel_s = 1'b0;
          end
          2'b11: begin
            grant_any_s = 1'b1;
            grant_sel_s = prio_r;
          end
          default: begin
            grant_any_s = 1'b0;
            grant_sel_s = 1'b0;
          end
        endcase
      end
      LOCK: begin
        grant_any_s = 1'b1;
        grant_sel_s = lock_sel_r;
      end
      default: begin
        grant_any_s = 1'b0;
        grant_sel_s = 1'b0;
      end
    endcase
  end

  assign ready1_s = rst_n && load_s && grant_any_s && grant_sel_s;
  assign ready2_s = rst_n && load_s && grant_any_s && !grant_sel_s;
  assign acc1_s   = ready1_s && din1.valid;
  assign acc2_s   = ready2_s && din2.valid;
  assign accept_s = acc1_s || acc2_s;

  // Accepted-beat mux.
  always_comb begin
    beat_sel_s  = acc1_s;
    beat_data_s = '0;
    beat_last_s = 1'b0;
    if (acc1_s) begin
      beat_data_s = din1.data;
      beat_last_s = din1.last;
    end else begin
      beat_data_s = din2.data;
      beat_last_s = din2.last;
    end
  end

  // Lock and priority next state; only packet ends move the pointer.
  always_comb begin
    state_next_s    = state_r;
    lock_sel_next_s = lock_sel_r;
    prio_next_s     = prio_r;
    if (accept_s) begin
      if (beat_last_s) begin
        state_next_s = IDLE;
        prio_next_s  = !beat_sel_s;
      end else begin
        state_next_s    = LOCK;
        lock_sel_next_s = beat_sel_s;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      lock_sel_r <= 1'b0;
      prio_r     <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      lock_sel_r <= lock_sel_next_s;
      prio_r     <= prio_next_s;
    end
  end

  // Output register: load on accept, clear valid when drained, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_sel_r   <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= beat_data_s;
      out_last_r  <= beat_last_s;
      out_sel_r   <= beat_sel_s;
    end else if (dout.ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign din1.ready = ready1_s;
  assign din2.ready = ready2_s;
  assign dout.valid = out_valid_r;
  assign dout.data  = out_data_r;
  assign dout.last  = out_last_r;
  assign dout.sel   = out_sel_r;

endmodule

// File: tb/tb_stream_merge_2to1.sv
// Self-checking bench for stream_merge_2to1: directed scenarios plus randomized
// packets checked against a packet-level round-robin model.
module tb_stream_merge_2to1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       sel;
    int         gap;
    int         cyc;
  } beat_t;

  logic clk;
  logic rst_n;
  int   cmp_cnt;
  int   err_cnt;

  beat_t q1[$];
  beat_t q2[$];
  beat_t obs[$];
  beat_t exp_q[$];

  stream_merge_2to1_if #(.WIDTH(8)) in1 ();
  stream_merge_2to1_if #(.WIDTH(8)) in2 ();
  stream_merge_2to1_if #(.WIDTH(8)) out ();

  assign in1.sel = 1'b0;
  assign in2.sel = 1'b0;

  stream_merge_2to1 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din1 (in1),
    .din2 (in2),
    .dout (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t mk(input logic [7:0] d, input logic l, input logic s, input int g);
    beat_t b;
    b.data = d;
    b.last = l;
    b.sel  = s;
    b.gap  = g;
    b.cyc  = 0;
    return b;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    in1.valid = 1'b0;
    in2.valid = 1'b0;
    out.ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drives q1/q2 as hold-until-accepted sources and records every output transfer.
  task automatic run_queues(input int max_cycles, input int ready_pct,
                            output int viol, output int both_rdy,
                            output int hold_err, output bit timeout);
    bit    in_pkt1, in_pkt2, a1, a2, prev_stall;
    beat_t h, prev_out, o;
    int    cyc;
    viol = 0; both_rdy = 0; hold_err = 0; timeout = 1'b0;
    in_pkt1 = 1'b0; in_pkt2 = 1'b0; prev_stall = 1'b0; cyc = 0;
    prev_out = mk(8'h00, 1'b0, 1'b0, 0);
    obs.delete();
    while (q1.size() > 0 || q2.size() > 0 || out.valid === 1'b1) begin
      if (cyc >= max_cycles) begin
        timeout = 1'b1;
        break;
      end
      if (q1.size() > 0 && q1[0].gap == 0) begin
        in1.valid = 1'b1; in1.data = q1[0].data; in1.last = q1[0].last;
      end else begin
        in1.valid = 1'b0;
      end
      if (q2.size() > 0 && q2[0].gap == 0) begin
        in2.valid = 1'b1; in2.data = q2[0].data; in2.last = q2[0].last;
      end else begin
        in2.valid = 1'b0;
      end
      out.ready = ($urandom_range(99) < ready_pct);
      #2;
      a1 = in1.valid && in1.ready;
      a2 = in2.valid && in2.ready;
      if (in1.ready && in2.ready) both_rdy++;
      if ((in1.ready && in_pkt2) || (in2.ready && in_pkt1)) viol++;
      if (prev_stall && (out.valid !== 1'b1 || out.data !== prev_out.data ||
                         out.last !== prev_out.last || out.sel !== prev_out.sel)) hold_err++;
      o = mk(out.data, out.last, out.sel, 0);
      o.cyc = cyc;
      if (out.valid && out.ready) obs.push_back(o);
      prev_stall = out.valid && !out.ready;
      prev_out = o;
      @(posedge clk); #1;
      if (a1) begin
        in_pkt1 = !q1[0].last;
        void'(q1.pop_front());
      end else if (q1.size() > 0 && q1[0].gap > 0) begin
        h = q1[0]; h.gap--; q1[0] = h;
      end
      if (a2) begin
        in_pkt2 = !q2[0].last;
        void'(q2.pop_front());
      end else if (q2.size() > 0 && q2[0].gap > 0) begin
        h = q2[0]; h.gap--; q2[0] = h;
      end
      cyc++;
    end
    in1.valid = 1'b0;
    in2.valid = 1'b0;
    out.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in1.valid = 1'b1; in1.data = 8'hFF; in1.last = 1'b1;
    in2.valid = 1'b1; in2.data = 8'hEE; in2.last = 1'b1;
    out.ready = 1'b1;
    #2;
    cmp_cnt++;
    if (in1.ready !== 1'b0 || in2.ready !== 1'b0) begin
      err_cnt++; $display("FAIL reset_ready: got %b/%b, expected 0/0", in1.ready, in2.ready);
    end
    @(posedge clk); #1;
    cmp_cnt++;
    if (out.valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b, expected 0", out.valid); end
    cmp_cnt++;
    if (out.data !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h, expected 00", out.data); end
    cmp_cnt++;
    if (out.last !== 1'b0) begin err_cnt++; $display("FAIL reset_last: got %b, expected 0", out.last); end
    cmp_cnt++;
    if (out.sel !== 1'b0) begin err_cnt++; $display("FAIL reset_sel: got %b, expected 0", out.sel); end
    in1.valid = 1'b0; in2.valid = 1'b0; out.ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    in1.valid = 1'b1; in1.data = 8'hA5; in1.last = 1'b1; out.ready = 1'b1;
    #1;
    cmp_cnt++;
    if (in1.ready !== 1'b1) begin err_cnt++; $display("FAIL single_ready: got %b, expected 1", in1.ready); end
    @(posedge clk); #1;
    in1.valid = 1'b0;
    cmp_cnt++;
    if (out.valid !== 1'b1 || out.data !== 8'hA5 || out.sel !== 1'b1 || out.last !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_out: got v=%b d=%h s=%b l=%b, expected v=1 d=a5 s=1 l=1",
               out.valid, out.data, out.sel, out.last);
    end
    @(posedge clk); #1;
    cmp_cnt++;
    if (out.valid !== 1'b0) begin err_cnt++; $display("FAIL single_drain: got %b, expected 0", out.valid); end
  endtask

  task automatic test_round_robin();
    int viol, both, hold; bit to;
    do_reset();
    q1.delete(); q2.delete(); exp_q.delete();
    q1.push_back(mk(8'h11, 1'b1, 1'b1, 0)); q1.push_back(mk(8'h12, 1'b1, 1'b1, 0));
    q2.push_back(mk(8'h21, 1'b1, 1'b0, 0)); q2.push_back(mk(8'h22, 1'b1, 1'b0, 0));
    exp_q.push_back(mk(8'h11, 1'b1, 1'b1, 0)); exp_q.push_back(mk(8'h21, 1'b1, 1'b0, 0));
    exp_q.push_back(mk(8'h12, 1'b1, 1'b1, 0)); exp_q.push_back(mk(8'h22, 1'b1, 1'b0, 0));
    run_queues(50, 100, viol, both, hold, to);
    cmp_cnt++;
    if (to || obs.size() != exp_q.size()) begin
      err_cnt++; $display("FAIL rr_count: got %0d beats (timeout=%b), expected %0d", obs.size(), to, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        cmp_cnt++;
        if (obs[i].data !== exp_q[i].data || obs[i].sel !== exp_q[i].sel || obs[i].last !== exp_q[i].last) begin
          err_cnt++;
          $display("FAIL rr_beat%0d: got d=%h s=%b l=%b, expected d=%h s=%b l=%b", i,
                   obs[i].data, obs[i].sel, obs[i].last, exp_q[i].data, exp_q[i].sel, exp_q[i].last);
        end
        cmp_cnt++;
        if (obs[i].cyc != obs[0].cyc + i) begin
          err_cnt++; $display("FAIL rr_gap%0d: got cycle %0d, expected %0d", i, obs[i].cyc, obs[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_packet_lock();
    int viol, both, hold; bit to;
    do_reset();
    q1.delete(); q2.delete(); exp_q.delete();
    q1.push_back(mk(8'h01, 1'b0, 1'b1, 0)); q1.push_back(mk(8'h02, 1'b0, 1'b1, 0));
    q1.push_back(mk(8'h03, 1'b1, 1'b1, 0));
    q2.push_back(mk(8'h55, 1'b1, 1'b0, 0));
    exp_q = q1;
    exp_q.push_back(q2[0]);
    run_queues(50, 100, viol, both, hold, to);
    cmp_cnt++;
    if (viol != 0) begin err_cnt++; $display("FAIL lock_viol: got %0d interleave grants, expected 0", viol); end
    cmp_cnt++;
    if (to || obs.size() != exp_q.size()) begin
      err_cnt++; $display("FAIL lock_count: got %0d beats (timeout=%b), expected %0d", obs.size(), to, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        cmp_cnt++;
        if (obs[i].data !== exp_q[i].data || obs[i].sel !== exp_q[i].sel || obs[i].last !== exp_q[i].last) begin
          err_cnt++;
          $display("FAIL lock_beat%0d: got d=%h s=%b l=%b, expected d=%h s=%b l=%b", i,
                   obs[i].data, obs[i].sel, obs[i].last, exp_q[i].data, exp_q[i].sel, exp_q[i].last);
        end
      end
    end
  endtask

  task automatic test_lock_idle_source();
    int viol, both, hold; bit to;
    do_reset();
    q1.delete(); q2.delete(); exp_q.delete();
    q1.push_back(mk(8'h66, 1'b1, 1'b1, 1));
    q2.push_back(mk(8'h77, 1'b0, 1'b0, 0)); q2.push_back(mk(8'h78, 1'b1, 1'b0, 2));
    exp_q.push_back(mk(8'h77, 1'b0, 1'b0, 0)); exp_q.push_back(mk(8'h78, 1'b1, 1'b0, 0));
    exp_q.push_back(mk(8'h66, 1'b1, 1'b1, 0));
    run_queues(50, 100, viol, both, hold, to);
    cmp_cnt++;
    if (viol != 0) begin err_cnt++; $display("FAIL idle_lock_viol: got %0d foreign grants, expected 0", viol); end
    cmp_cnt++;
    if (to || obs.size() != exp_q.size()) begin
      err_cnt++; $display("FAIL idle_lock_count: got %0d beats (timeout=%b), expected %0d", obs.size(), to, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        cmp_cnt++;
        if (obs[i].data !== exp_q[i].data || obs[i].sel !== exp_q[i].sel) begin
          err_cnt++;
          $display("FAIL idle_lock_beat%0d: got d=%h s=%b, expected d=%h s=%b", i,
                   obs[i].data, obs[i].sel, exp_q[i].data, exp_q[i].sel);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in1.valid = 1'b1; in1.data = 8'h3C; in1.last = 1'b1; out.ready = 1'b1;
    @(posedge clk); #1;
    in1.data = 8'h3D;
    in2.valid = 1'b1; in2.data = 8'h4D; in2.last = 1'b1;
    out.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      cmp_cnt++;
      if (out.valid !== 1'b1 || out.data !== 8'h3C) begin
        err_cnt++; $display("FAIL bp_hold%0d: got v=%b d=%h, expected v=1 d=3c", i, out.valid, out.data);
      end
      cmp_cnt++;
      if (in1.ready !== 1'b0 || in2.ready !== 1'b0) begin
        err_cnt++; $display("FAIL bp_ready%0d: got %b/%b, expected 0/0", i, in1.ready, in2.ready);
      end
      @(posedge clk); #1;
    end
    out.ready = 1'b1;
    #1;
    cmp_cnt++;
    if (in1.ready !== 1'b0 || in2.ready !== 1'b1) begin
      err_cnt++; $display("FAIL bp_release: got %b/%b, expected 0/1", in1.ready, in2.ready);
    end
    @(posedge clk); #1;
    in1.valid = 1'b0; in2.valid = 1'b0;
    cmp_cnt++;
    if (out.valid !== 1'b1 || out.data !== 8'h4D || out.sel !== 1'b0) begin
      err_cnt++; $display("FAIL bp_next: got v=%b d=%h s=%b, expected v=1 d=4d s=0", out.valid, out.data, out.sel);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    in2.valid = 1'b1; in2.data = 8'h90; in2.last = 1'b0; out.ready = 1'b1;
    @(posedge clk); #1;
    cmp_cnt++;
    if (out.valid !== 1'b1 || out.data !== 8'h90 || out.sel !== 1'b0) begin
      err_cnt++; $display("FAIL mid_first: got v=%b d=%h s=%b, expected v=1 d=90 s=0", out.valid, out.data, out.sel);
    end
    in2.data = 8'h91; in2.last = 1'b1;
    in1.valid = 1'b1; in1.data = 8'h1A; in1.last = 1'b1;
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (in1.ready !== 1'b0 || in2.ready !== 1'b0) begin
      err_cnt++; $display("FAIL mid_rst_ready: got %b/%b, expected 0/0", in1.ready, in2.ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_cnt++;
    if (out.valid !== 1'b0) begin err_cnt++; $display("FAIL mid_dropped: got %b, expected 0", out.valid); end
    #1;
    cmp_cnt++;
    if (in1.ready !== 1'b1 || in2.ready !== 1'b0) begin
      err_cnt++; $display("FAIL mid_grant: got %b/%b, expected 1/0", in1.ready, in2.ready);
    end
    @(posedge clk); #1;
    in1.valid = 1'b0; in2.valid = 1'b0;
    cmp_cnt++;
    if (out.valid !== 1'b1 || out.data !== 8'h1A || out.sel !== 1'b1) begin
      err_cnt++; $display("FAIL mid_after: got v=%b d=%h s=%b, expected v=1 d=1a s=1", out.valid, out.data, out.sel);
    end
  endtask

  // Random packets on both always-offering channels; the model alternates whole packets.
  task automatic test_random();
    int viol, both, hold, n, len; bit to, turn; beat_t b;
    beat_t c1[$];
    beat_t c2[$];
    for (int r = 0; r < 4; r++) begin
      do_reset();
      q1.delete(); q2.delete(); exp_q.delete();
      for (int ch = 0; ch < 2; ch++) begin
        n = $urandom_range(6, 2);
        for (int p = 0; p < n; p++) begin
          len = $urandom_range(4, 1);
          for (int k = 0; k < len; k++) begin
            b = mk(8'($urandom), (k == len - 1), 1'b0, 0);
            if (ch == 0) q1.push_back(b); else q2.push_back(b);
          end
        end
      end
      c1 = q1; c2 = q2; turn = 1'b1;
      while (c1.size() > 0 || c2.size() > 0) begin
        if (turn && c1.size() == 0) turn = 1'b0;
        else if (!turn && c2.size() == 0) turn = 1'b1;
        do begin
          if (turn) b = c1.pop_front(); else b = c2.pop_front();
          b.sel = turn;
          exp_q.push_back(b);
        end while (!b.last);
        turn = !turn;
      end
      run_queues(2000, 60, viol, both, hold, to);
      cmp_cnt++;
      if (viol != 0 || both != 0) begin
        err_cnt++; $display("FAIL rand%0d_grant: got %0d interleave / %0d dual-ready, expected 0/0", r, viol, both);
      end
      cmp_cnt++;
      if (hold != 0) begin err_cnt++; $display("FAIL rand%0d_hold: got %0d unstable stalls, expected 0", r, hold); end
      cmp_cnt++;
      if (to || obs.size() != exp_q.size()) begin
        err_cnt++;
        $display("FAIL rand%0d_count: got %0d beats (timeout=%b), expected %0d", r, obs.size(), to, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          cmp_cnt++;
          if (obs[i].data !== exp_q[i].data || obs[i].sel !== exp_q[i].sel || obs[i].last !== exp_q[i].last) begin
            err_cnt++;
            $display("FAIL rand%0d_beat%0d: got d=%h s=%b l=%b, expected d=%h s=%b l=%b", r, i,
                     obs[i].data, obs[i].sel, obs[i].last, exp_q[i].data, exp_q[i].sel, exp_q[i].last);
          end
        end
      end
    end
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    in1.valid = 1'b0; in1.data = 8'h00; in1.last = 1'b0;
    in2.valid = 1'b0; in2.data = 8'h00; in2.last = 1'b0;
    out.ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_lock_idle_source();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
